icache_direct: RTL and testbench

- Direct-mapped, one-word-per-block instruction cache between the fetch stage of one core and the instruction port of the dual-core memory controller.
- One instance per CPU.
- Serves fetch hits combinationally.
- On a miss, issues a single-word read (iREN/iaddr) and waits on iwait/iload.
- Has no coherence role. The flush input invalidates all frames, for halt and self-modifying-code support.

---
 rtl/icache_direct.sv | 121 ++++++++++++
 tb/tb_icache_direct.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-frame instruction cache.
// Hits are served combinationally from the frame array. A miss latches the
// word address and holds a single-word read to the memory controller until
// iwait drops. flush invalidates every frame and aborts an in-flight fill.
module icache_direct #(
  parameter int FRAMES = 16,
  parameter int CNTW   = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            imemREN,
  input  logic [31:0]     imemaddr,
  output logic            ihit,
  output logic [31:0]     imemload,
  input  logic            flush,
  output logic            iREN,
  output logic [31:0]     iaddr,
  input  logic            iwait,
  input  logic [31:0]     iload,
  output logic [CNTW-1:0] hit_count,
  output logic [CNTW-1:0] miss_count
);
  localparam int IB = $clog2(FRAMES);
  localparam int TW = 30 - IB;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]                  state_q, state_d;
  logic [FRAMES-1:0]           valid_q, valid_d;
  logic [FRAMES-1:0][TW-1:0]   tag_q, tag_d;
  logic [FRAMES-1:0][31:0]     data_q, data_d;
  logic [29:0]                 maddr_q, maddr_d;   // word address of the pending fill
  logic [CNTW-1:0]             hit_cnt_q, hit_cnt_d;
  logic [CNTW-1:0]             miss_cnt_q, miss_cnt_d;

  logic [IB-1:0] idx, midx;
  logic [TW-1:0] tag, mtag;
  logic          hit, miss, fill_done;
  logic          unused_addr_lsb;

  assign idx  = imemaddr[IB+1:2];
  assign tag  = imemaddr[31:IB+2];
  assign midx = maddr_q[IB-1:0];
  assign mtag = maddr_q[29:IB];
  assign unused_addr_lsb = ^imemaddr[1:0];

  assign hit       = (state_q == IDLE) && imemREN && !flush && valid_q[idx] && (tag_q[idx] == tag);
  assign miss      = (state_q == IDLE) && imemREN && !flush && !hit;
  assign fill_done = (state_q == FILL) && !iwait && !flush;

  assign ihit       = hit;
  assign imemload   = hit ? data_q[idx] : 32'h0;
  assign iREN       = (state_q == FILL);
  assign iaddr      = (state_q == FILL) ? {maddr_q, 2'b00} : 32'h0;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  // Next-state: FSM, frame array writes, flush invalidation, saturating stats.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    maddr_d    = maddr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    case (state_q)
      IDLE: begin
        if (miss) begin
          maddr_d = imemaddr[31:2];
          state_d = FILL;
        end
      end
      FILL: begin
        // Fill completes for the latched address regardless of current fetch.
        if (flush) begin
          state_d = IDLE;
        end else if (!iwait) begin
          valid_d[midx] = 1'b1;
          tag_d[midx]   = mtag;
          data_d[midx]  = iload;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // flush wins over a same-cycle fill write.
    if (flush) valid_d = '0;

    if (hit  && (hit_cnt_q  != {CNTW{1'b1}})) hit_cnt_d  = hit_cnt_q  + 1'b1;
    if (miss && (miss_cnt_q != {CNTW{1'b1}})) miss_cnt_d = miss_cnt_q + 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      maddr_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      maddr_q    <= maddr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // fill_done is kept as a named term for readability of the FILL exit.
  logic unused_fill_done;
  assign unused_fill_done = fill_done;
endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct. Two instances share stimulus: the
// default one (CNTW=32) and a narrow-counter one (CNTW=4) for saturation.
module tb_icache_direct;
  logic        CLK = 1'b0;
  logic        RST, imemREN, flush, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN, ihit4, iREN4;
  logic [31:0] imemload, iaddr, imemload4, iaddr4;
  logic [31:0] hit_count, miss_count;
  logic [3:0]  hit_count4, miss_count4;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  icache_direct #(.FRAMES(16), .CNTW(32)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  icache_direct #(.FRAMES(16), .CNTW(4)) dut4 (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit4), .imemload(imemload4), .flush(flush), .iREN(iREN4),
    .iaddr(iaddr4), .iwait(iwait), .iload(iload),
    .hit_count(hit_count4), .miss_count(miss_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Miss on a, stall nw cycles, deliver d, then check the refetch hit (not clocked).
  task automatic fill(input string tag, input logic [31:0] a, input logic [31:0] d, input int nw);
    imemaddr = a; imemREN = 1'b1; iwait = 1'b1;
    #1 chk({tag, "_miss"}, {31'b0, ihit}, 32'd0);
    tick();
    for (int i = 0; i < nw; i++) begin
      #1 chk({tag, "_iren"}, {31'b0, iREN}, 32'd1);
      chk({tag, "_iaddr"}, iaddr, a);
      tick();
    end
    iwait = 1'b0; iload = d;
    #1 chk({tag, "_iaddr_last"}, iaddr, a);
    tick();
    iwait = 1'b1; iload = 32'h0;
    #1 chk({tag, "_hit"}, {31'b0, ihit}, 32'd1);
    chk({tag, "_load"}, imemload, d);
    chk({tag, "_iren_idle"}, {31'b0, iREN}, 32'd0);
  endtask

  initial begin
    RST = 1'b1; imemREN = 1'b0; flush = 1'b0; iwait = 1'b1;
    imemaddr = 32'h0; iload = 32'h0;
    tick(); tick();
    RST = 1'b0;
    #1 chk("rst_ihit", {31'b0, ihit}, 32'd0);
    chk("rst_load", imemload, 32'd0);
    chk("rst_iren", {31'b0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_hitc", hit_count, 32'd0);
    chk("rst_missc", miss_count, 32'd0);

    // 1: cold fetch of 0x40, 3 stall cycles + 1 data cycle
    fill("t1", 32'h40, 32'h8C220004, 3);
    chk("t1_missc", miss_count, 32'd1);
    chk("t1_hitc0", hit_count, 32'd0);
    tick();
    chk("t1_hitc", hit_count, 32'd1);

    // 2: five more hit cycles
    for (int i = 0; i < 5; i++) begin
      #1 chk("t2_hit", {31'b0, ihit}, 32'd1);
      chk("t2_iren", {31'b0, iREN}, 32'd0);
      tick();
    end
    chk("t2_hitc", hit_count, 32'd6);

    // 3: conflict at index 0
    fill("t3a", 32'h00, 32'h11111111, 1);
    fill("t3b", 32'h40, 32'h22222222, 1);
    fill("t3c", 32'h00, 32'h11111111, 2);
    chk("t3_missc", miss_count, 32'd4);
    chk("t3_hitc", hit_count, 32'd6);

    // 4: address changes during a fill; latched address is held
    imemaddr = 32'h80; imemREN = 1'b1; iwait = 1'b1;
    #1 chk("t4_miss", {31'b0, ihit}, 32'd0);
    tick();
    imemaddr = 32'h84;
    #1 chk("t4_iaddr0", iaddr, 32'h80);
    tick();
    #1 chk("t4_iaddr1", iaddr, 32'h80);
    iwait = 1'b0; iload = 32'hAAAA0080;
    tick();
    iwait = 1'b1;
    #1 chk("t4_84miss", {31'b0, ihit}, 32'd0);
    fill("t4b", 32'h84, 32'hBBBB0084, 0);
    imemaddr = 32'h80;
    #1 chk("t4_80hit", {31'b0, ihit}, 32'd1);
    chk("t4_80load", imemload, 32'hAAAA0080);
    chk("t4_missc", miss_count, 32'd6);

    // 5: flush during FILL with data arriving the same cycle
    imemaddr = 32'h40;
    #1 chk("t5_miss", {31'b0, ihit}, 32'd0);
    tick();
    flush = 1'b1; iwait = 1'b0; iload = 32'hDEADBEEF;
    #1 chk("t5_iren_fill", {31'b0, iREN}, 32'd1);
    tick();
    flush = 1'b0; iwait = 1'b1; imemREN = 1'b0;
    #1 chk("t5_iren_off", {31'b0, iREN}, 32'd0);
    chk("t5_missc", miss_count, 32'd7);
    imemREN = 1'b1; imemaddr = 32'h40;
    #1 chk("t5_40miss", {31'b0, ihit}, 32'd0);
    imemaddr = 32'h84;
    #1 chk("t5_84miss", {31'b0, ihit}, 32'd0);
    fill("t5r", 32'h80, 32'hAAAA0080, 1);
    // flush in IDLE: forces ihit low, no miss started
    flush = 1'b1;
    #1 chk("t5_flush_ihit", {31'b0, ihit}, 32'd0);
    tick();
    flush = 1'b0;
    #1 chk("t5_flush_iren", {31'b0, iREN}, 32'd0);
    chk("t5_flush_missc", miss_count, 32'd8);
    chk("t5_flush_inval", {31'b0, ihit}, 32'd0);

    // 6: saturation on the narrow instance
    fill("t6", 32'h80, 32'hAAAA0080, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("t6_hitc32", hit_count, 32'd26);
    chk("t6_hitc4", {28'b0, hit_count4}, 32'd15);
    chk("t6_missc4", {28'b0, miss_count4}, 32'd9);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1 chk("t6_rst_hitc4", {28'b0, hit_count4}, 32'd0);
    chk("t6_rst_missc4", {28'b0, miss_count4}, 32'd0);
    chk("t6_rst_hitc", hit_count, 32'd0);
    chk("t6_rst_ihit", {31'b0, ihit}, 32'd0);

    // RST mid-FILL: iREN drops, no write
    imemaddr = 32'h80; imemREN = 1'b1; iwait = 1'b1;
    tick();
    #1 chk("rf_iren", {31'b0, iREN}, 32'd1);
    RST = 1'b1; iwait = 1'b0; iload = 32'h12345678;
    tick();
    RST = 1'b0; iwait = 1'b1; imemREN = 1'b0;
    #1 chk("rf_iren_off", {31'b0, iREN}, 32'd0);
    chk("rf_iaddr_off", iaddr, 32'd0);
    imemREN = 1'b1;
    #1 chk("rf_nowrite", {31'b0, ihit}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
